// File: rtl/result_frame_pkg.sv
// Shared types and constants for the result frame UART transmitter.
// RESULT_TX_PARITY_EN adds the PARITY character state.
package result_frame_pkg;

  localparam logic [7:0] FRAME_TYPE  = 8'h01;
  localparam logic [7:0] FRAME_PARAM = 8'h02;
  localparam logic [2:0] FRAME1_LEN  = 3'd4;
  localparam logic [2:0] FRAME2_LEN  = 3'd5;

  // Signal-type codes produced by the judge block
  localparam logic [2:0] SIG_NONE    = 3'd0;
  localparam logic [2:0] SIG_AM      = 3'd1;
  localparam logic [2:0] SIG_FM      = 3'd2;
  localparam logic [2:0] SIG_ASK     = 3'd3;
  localparam logic [2:0] SIG_FSK     = 3'd4;
  localparam logic [2:0] SIG_PSK     = 3'd5;
  localparam logic [2:0] SIG_CW      = 3'd6;
  localparam logic [2:0] SIG_UNKNOWN = 3'd7;

  // Per-character bit-level states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef RESULT_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } tx_state_t;

  // Frame-level states
  typedef enum logic [1:0] {
    FR_IDLE,
    FR_SEND,
    FR_DONE
  } frame_state_t;

  typedef enum logic {
    SEL_TYPE,
    SEL_PARAM
  } frame_sel_t;

  typedef struct packed {
    frame_sel_t  sel;
    logic [2:0]  sig_type;
    logic [15:0] sig_param;
  } frame_req_t;

  function automatic logic [2:0] frame_last(input frame_sel_t sel);
    return (sel == SEL_TYPE) ? (FRAME1_LEN - 3'd1) : (FRAME2_LEN - 3'd1);
  endfunction

endpackage

// File: rtl/result_frame_tx_uart_byte_tx.sv
// One UART character per start: START, 8 data bits LSB first, optional even
// parity (RESULT_TX_PARITY_EN), STOP. done is high in the last STOP cycle.
module uart_byte_tx
  import result_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       done
);

  tx_state_t   state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        par_q, par_d;
  logic        txd_q, txd_d;
  logic        bit_end;

  assign bit_end = (cnt_q == 10'(CLKS_PER_BIT - 1));
  assign txd     = txd_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

  // txd is registered with the next state so the pin never glitches.
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? 10'd0 : cnt_q + 10'd1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    txd_d   = txd_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        txd_d = 1'b1;
        if (start) begin
          state_d = ST_START;
          shreg_d = data;
          par_d   = ^data;
          txd_d   = 1'b0;
        end
      end
      ST_START: if (bit_end) begin
        state_d = ST_DATA;
        bit_d   = '0;
        txd_d   = shreg_q[0];
      end
      ST_DATA: if (bit_end) begin
        if (bit_q == 3'd7) begin
`ifdef RESULT_TX_PARITY_EN
          state_d = ST_PARITY;
          txd_d   = par_q;
`else
          state_d = ST_STOP;
          txd_d   = 1'b1;
`endif
        end else begin
          bit_d   = bit_q + 3'd1;
          shreg_d = {1'b0, shreg_q[7:1]};
          txd_d   = shreg_q[1];
        end
      end
`ifdef RESULT_TX_PARITY_EN
      ST_PARITY: if (bit_end) begin
        state_d = ST_STOP;
        txd_d   = 1'b1;
      end
`endif
      ST_STOP: if (bit_end) begin
        done = 1'b1;
        if (start) begin
          state_d = ST_START;
          shreg_d = data;
          par_d   = ^data;
          txd_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/result_frame_tx.sv
// Sends the type (frame 1) or parameter (frame 2) result frame over UART on
// each accepted transmit_trigger. RESULT_TX_PARITY_EN selects 8E1 characters.
module result_frame_tx
  import result_frame_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] HDR_BYTE     = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        meas_trigger,
  input  logic        transmit_trigger,
  input  logic [2:0]  sig_type,
  input  logic [15:0] sig_param,
  output logic        txd,
  output logic        busy,
  output logic        frame_done,
  output logic        trig_dropped
);

  frame_state_t fst_q, fst_d;
  frame_req_t   req_q, req_d;
  frame_sel_t   next_sel_q, next_sel_d, cur_sel;
  logic [2:0]   byte_q, byte_d, nidx;
  logic [7:0]   csum_q, csum_d, nxt_byte;
  logic         nxt_is_csum;
  logic         drop_q;
  logic         tx_start, tx_done;
  logic [7:0]   tx_data;

  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk   (clk),
    .rst_n (rst_n),
    .start (tx_start),
    .data  (tx_data),
    .txd   (txd),
    .done  (tx_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fst_q      <= FR_IDLE;
      req_q      <= '0;
      next_sel_q <= SEL_TYPE;
      byte_q     <= '0;
      csum_q     <= '0;
      drop_q     <= 1'b0;
    end else begin
      fst_q      <= fst_d;
      req_q      <= req_d;
      next_sel_q <= next_sel_d;
      byte_q     <= byte_d;
      csum_q     <= csum_d;
      // Anything not taken in IDLE is reported, including the DONE cycle.
      drop_q     <= transmit_trigger && (fst_q != FR_IDLE);
    end
  end

  assign busy         = (fst_q == FR_SEND);
  assign frame_done   = (fst_q == FR_DONE);
  assign trig_dropped = drop_q;

  // Byte that follows byte_q within the latched frame.
  always_comb begin
    nidx        = byte_q + 3'd1;
    nxt_is_csum = (nidx == frame_last(req_q.sel));
    nxt_byte    = 8'h00;
    if (nxt_is_csum) begin
      nxt_byte = csum_q;
    end else begin
      case (nidx)
        3'd1:    nxt_byte = (req_q.sel == SEL_TYPE) ? FRAME_TYPE : FRAME_PARAM;
        3'd2:    nxt_byte = (req_q.sel == SEL_TYPE) ? {5'b0, req_q.sig_type}
                                                    : req_q.sig_param[15:8];
        3'd3:    nxt_byte = req_q.sig_param[7:0];
        default: nxt_byte = 8'h00;
      endcase
    end
  end

  // meas_trigger rearms before the accept decision, so a same-cycle pair
  // sends frame 1.
  always_comb begin
    fst_d      = fst_q;
    req_d      = req_q;
    byte_d     = byte_q;
    csum_d     = csum_q;
    next_sel_d = meas_trigger ? SEL_TYPE : next_sel_q;
    cur_sel    = meas_trigger ? SEL_TYPE : next_sel_q;
    tx_start   = 1'b0;
    tx_data    = HDR_BYTE;
    case (fst_q)
      FR_IDLE: if (transmit_trigger) begin
        fst_d      = FR_SEND;
        req_d      = '{sel: cur_sel, sig_type: sig_type, sig_param: sig_param};
        next_sel_d = (cur_sel == SEL_TYPE) ? SEL_PARAM : SEL_TYPE;
        byte_d     = '0;
        csum_d     = '0;
        tx_start   = 1'b1;
        tx_data    = HDR_BYTE;
      end
      FR_SEND: if (tx_done) begin
        if (byte_q == frame_last(req_q.sel)) begin
          fst_d = FR_DONE;
        end else begin
          byte_d   = nidx;
          tx_start = 1'b1;
          tx_data  = nxt_byte;
          if (!nxt_is_csum) csum_d = csum_q + nxt_byte;
        end
      end
      FR_DONE: fst_d = FR_IDLE;
      default: fst_d = FR_IDLE;
    endcase
  end

endmodule

// File: tb/tb_result_frame_tx.sv
// Directed bench for result_frame_tx: decodes txd at bit centres and compares
// against hand-computed frames.
module tb_result_frame_tx;

  localparam int CPB = 16;
`ifdef RESULT_TX_PARITY_EN
  localparam int CHAR = 11;
`else
  localparam int CHAR = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        meas_trigger = 1'b0;
  logic        transmit_trigger = 1'b0;
  logic [2:0]  sig_type = 3'd0;
  logic [15:0] sig_param = 16'h0;
  logic        txd, busy, frame_done, trig_dropped;

  int checks = 0;
  int passes = 0;
  int busy_bad, frame_bad, drop_cnt;
  logic [7:0] rx [5];
  logic       par [5];

  result_frame_tx #(.CLKS_PER_BIT(CPB), .HDR_BYTE(8'hA5)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .meas_trigger     (meas_trigger),
    .transmit_trigger (transmit_trigger),
    .sig_type         (sig_type),
    .sig_param        (sig_param),
    .txd              (txd),
    .busy             (busy),
    .frame_done       (frame_done),
    .trig_dropped     (trig_dropped)
  );

  always #5 clk = ~clk;

  // Pulse the trigger for one cycle; returns at the negedge of frame cycle 1.
  task automatic fire(input logic meas);
    transmit_trigger = 1'b1;
    meas_trigger     = meas;
    @(negedge clk);
    transmit_trigger = 1'b0;
    meas_trigger     = 1'b0;
  endtask

  // Walks one frame cycle by cycle, optionally injecting a trigger or a
  // meas_trigger at a given frame cycle. Ends at the DONE-cycle negedge.
  task automatic capture(input int nbytes, input int drop_at, input int meas_at);
    int k, s, ph;
    busy_bad = 0; frame_bad = 0; drop_cnt = 0;
    for (int c = 0; c < nbytes * CHAR * CPB; c++) begin
      k  = c / (CHAR * CPB);
      s  = (c % (CHAR * CPB)) / CPB;
      ph = c % CPB;
      if (busy !== 1'b1) busy_bad++;
      if (trig_dropped === 1'b1) drop_cnt++;
      if (ph == CPB / 2) begin
        if (s == 0) begin
          if (txd !== 1'b0) frame_bad++;
        end else if (s <= 8) begin
          rx[k][s-1] = txd;
        end else if (s == CHAR - 1) begin
          if (txd !== 1'b1) frame_bad++;
        end else begin
          par[k] = txd;
        end
      end
      transmit_trigger = (c == drop_at);
      meas_trigger     = (c == meas_at);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (txd !== 1'b1) $display("FAIL reset_txd got %b want 1", txd); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
    checks++; if (frame_done !== 1'b0) $display("FAIL reset_done got %b want 0", frame_done); else passes++;
    checks++; if (trig_dropped !== 1'b0) $display("FAIL reset_drop got %b want 0", trig_dropped); else passes++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_frame1;
    logic [7:0] e [4];
    e = '{8'hA5, 8'h01, 8'h03, 8'h04};
    meas_trigger = 1'b1; @(negedge clk); meas_trigger = 1'b0;
    sig_type = 3'd3;
    fire(1'b0);
    sig_type = 3'd5;
    checks++; if (txd !== 1'b0 || busy !== 1'b1)
      $display("FAIL f1_start got txd=%b busy=%b want 0/1", txd, busy); else passes++;
    capture(4, -1, -1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rx[k] !== e[k]) $display("FAIL f1_byte%0d got %02h want %02h", k, rx[k], e[k]);
      else passes++;
    end
    checks++; if (busy_bad != 0 || frame_bad != 0)
      $display("FAIL f1_framing got busy_bad=%0d frame_bad=%0d want 0/0", busy_bad, frame_bad); else passes++;
    checks++; if (frame_done !== 1'b1 || busy !== 1'b0)
      $display("FAIL f1_done got done=%b busy=%b want 1/0", frame_done, busy); else passes++;
    @(negedge clk);
    checks++; if (frame_done !== 1'b0) $display("FAIL f1_done_pulse got %b want 0", frame_done); else passes++;
  endtask

  task automatic test_frame2;
    logic [7:0] e [5];
    logic [7:0] e1 [4];
    e  = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h48};
    e1 = '{8'hA5, 8'h01, 8'h06, 8'h07};
    sig_param = 16'h1234;
    fire(1'b0);
    sig_param = 16'hFFFF;
    capture(5, -1, -1);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rx[k] !== e[k]) $display("FAIL f2_byte%0d got %02h want %02h", k, rx[k], e[k]);
      else passes++;
    end
    checks++; if (busy_bad != 0 || frame_bad != 0)
      $display("FAIL f2_framing got busy_bad=%0d frame_bad=%0d want 0/0", busy_bad, frame_bad); else passes++;
    checks++; if (frame_done !== 1'b1) $display("FAIL f2_done got %b want 1", frame_done); else passes++;
    @(negedge clk);
    sig_type = 3'd6;
    fire(1'b0);
    capture(4, -1, -1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rx[k] !== e1[k]) $display("FAIL f2_wrap_byte%0d got %02h want %02h", k, rx[k], e1[k]);
      else passes++;
    end
    @(negedge clk);
  endtask

  task automatic test_dropped;
    logic [7:0] e [4];
    logic [7:0] e2 [5];
    e  = '{8'hA5, 8'h01, 8'h02, 8'h03};
    e2 = '{8'hA5, 8'h02, 8'h00, 8'hFF, 8'h01};
    meas_trigger = 1'b1; @(negedge clk); meas_trigger = 1'b0;
    sig_type = 3'd2;
    fire(1'b0);
    capture(4, 100, -1);
    checks++; if (drop_cnt != 1) $display("FAIL drop_pulse got %0d want 1", drop_cnt); else passes++;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rx[k] !== e[k]) $display("FAIL drop_byte%0d got %02h want %02h", k, rx[k], e[k]);
      else passes++;
    end
    @(negedge clk);
    sig_param = 16'h00FF;
    fire(1'b0);
    capture(5, -1, -1);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rx[k] !== e2[k]) $display("FAIL drop_next_byte%0d got %02h want %02h", k, rx[k], e2[k]);
      else passes++;
    end
    @(negedge clk);
  endtask

  task automatic test_meas;
    logic [7:0] e [4];
    sig_type = 3'd1;
    fire(1'b0);
    capture(4, -1, -1);
    checks++; if (rx[1] !== 8'h01 || rx[3] !== 8'h02)
      $display("FAIL meas_pre got id=%02h cs=%02h want 01/02", rx[1], rx[3]); else passes++;
    @(negedge clk);
    sig_type = 3'd4;
    fire(1'b1);
    capture(4, -1, 200);
    e = '{8'hA5, 8'h01, 8'h04, 8'h05};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rx[k] !== e[k]) $display("FAIL meas_same_byte%0d got %02h want %02h", k, rx[k], e[k]);
      else passes++;
    end
    @(negedge clk);
    sig_type = 3'd0;
    fire(1'b0);
    capture(4, -1, -1);
    checks++; if (rx[1] !== 8'h01 || rx[2] !== 8'h00 || rx[3] !== 8'h01)
      $display("FAIL meas_mid got %02h %02h %02h want 01 00 01", rx[1], rx[2], rx[3]); else passes++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [7:0] e [4];
    e = '{8'hA5, 8'h01, 8'h05, 8'h06};
    sig_param = 16'h1234;
    fire(1'b0);
    repeat (299) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (txd !== 1'b1 || busy !== 1'b0)
      $display("FAIL rst_mid got txd=%b busy=%b want 1/0", txd, busy); else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    sig_type = 3'd5;
    fire(1'b0);
    capture(4, -1, -1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rx[k] !== e[k]) $display("FAIL rst_after_byte%0d got %02h want %02h", k, rx[k], e[k]);
      else passes++;
    end
    checks++; if (busy_bad != 0 || frame_bad != 0)
      $display("FAIL rst_after_framing got busy_bad=%0d frame_bad=%0d want 0/0", busy_bad, frame_bad); else passes++;
    @(negedge clk);
  endtask

`ifdef RESULT_TX_PARITY_EN
  task automatic test_parity;
    meas_trigger = 1'b1; @(negedge clk); meas_trigger = 1'b0;
    sig_type = 3'd7;
    fire(1'b0);
    capture(4, -1, -1);
    checks++; if (rx[2] !== 8'h07 || rx[3] !== 8'h08)
      $display("FAIL par_bytes got %02h %02h want 07 08", rx[2], rx[3]); else passes++;
    checks++; if ({par[0], par[1], par[2], par[3]} !== 4'b0111)
      $display("FAIL par_bits got %b%b%b%b want 0111", par[0], par[1], par[2], par[3]); else passes++;
    checks++; if (frame_done !== 1'b1 || busy_bad != 0)
      $display("FAIL par_len got done=%b busy_bad=%0d want 1/0", frame_done, busy_bad); else passes++;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_frame1();
    test_frame2();
    test_dropped();
    test_meas();
    test_reset_mid();
`ifdef RESULT_TX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/result_frame_tx.md
Name: result_frame_tx

Overview:
- Consumer of the controller's `transmit_trigger` pulses; sends the measurement result to the host over a UART link (8N1, LSB first).
- The first trigger after a measurement sends frame 1 (signal type). The second sends frame 2 (signal parameter).
- Sits beside the top-level FSM in the 1.8 MHz clock domain, driving the board TX pin.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit (1.8 MHz / 16 = 112500 baud); legal range 4..1023.
- HDR_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  system clock, 1.8 MHz.
- rst_n  in  1  synchronous active-low reset.
- meas_trigger  in  1  measurement-start pulse; rearms the frame index to frame 1.
- transmit_trigger  in  1  send-request pulse, 1 cycle wide.
- sig_type  in  3  signal-type code from the judge block.
- sig_param  in  16  signal parameter (frequency or modulation index).
- txd  out  1  UART serial output; idles high.
- busy  out  1  high while a frame is being shifted out.
- frame_done  out  1  1-cycle pulse after the last stop bit of a frame.
- trig_dropped  out  1  1-cycle pulse when a trigger arrives while busy.

Behaviour:
- Reset (rst_n low at a clk edge) forces: txd=1, busy=0, frame_done=0, trig_dropped=0, frame index=1, FSM=IDLE, all counters=0. Reset mid-frame aborts the frame immediately; txd returns high on the next edge.
- Frame contents:
  - Frame 1: HDR_BYTE, 8'h01, {5'b0, sig_type}, checksum (4 bytes).
  - Frame 2: HDR_BYTE, 8'h02, sig_param[15:8], sig_param[7:0], checksum (5 bytes).
  - Checksum = 8-bit sum, modulo 256, of all bytes after the header.
- Capture: sig_type and sig_param are latched on the edge that accepts the trigger. Later input changes do not affect the frame in flight.
- Accepting a trigger:
  - transmit_trigger high in IDLE is accepted.
  - The current frame index is latched, then the index toggles: 1→2, 2→1.
  - busy=1 and txd=0 (start bit) from the next edge.
- Busy triggers: a trigger while busy=1 is ignored and produces a trig_dropped pulse on the next edge. The frame index does not change.
- meas_trigger:
  - Sets the frame index to 1 on any cycle, including while busy; the frame in flight completes unchanged.
  - meas_trigger and transmit_trigger in the same cycle: meas_trigger applies first, so frame 1 is sent.
- FSM states:
  - IDLE → START on an accepted trigger.
  - START (txd=0, CLKS_PER_BIT cycles) → DATA.
  - DATA (8 bits, LSB first, CLKS_PER_BIT cycles each) → STOP.
  - STOP (txd=1, CLKS_PER_BIT cycles) → START if bytes remain, else DONE.
  - DONE (1 cycle) → IDLE; frame_done=1 and busy=0 in this cycle.
- Timing:
  - No idle gap between bytes.
  - Frame 1 occupies 40·CLKS_PER_BIT cycles, frame 2 occupies 50·CLKS_PER_BIT cycles. At default: 640 and 800 cycles, well inside the 18000-cycle transmit window.
- Width rules: bit-cycle counter is 10 bits, wraps to 0 at CLKS_PER_BIT-1. Bit index is 3 bits. Byte index is 3 bits.

Optional Feature:
- Macro: RESULT_TX_PARITY_EN.
- Defined: an even-parity bit is inserted between DATA and STOP. A PARITY state is added (txd = XOR of the 8 data bits, CLKS_PER_BIT cycles). Character length becomes 11 bits, so frames take 44·CLKS_PER_BIT and 55·CLKS_PER_BIT cycles.
- Undefined: plain 8N1 as above; the PARITY state does not exist.

Decomposition:
- Package result_frame_pkg:
  - Frame ID constants FRAME_TYPE=8'h01 and FRAME_PARAM=8'h02.
  - Frame length constants, 4 and 5.
  - Signal-type code constants (3-bit).
  - FSM state enum.
- Sub-module uart_byte_tx:
  - Interface: start/data[7:0] in, txd/done out; handles START/DATA/(PARITY)/STOP per byte.
  - The parent keeps frame index, byte index, checksum accumulation and the trigger/drop logic.

Test Plan:
- Frame 1: reset, meas_trigger, then transmit_trigger with sig_type=3 → txd carries A5 01 03 04. busy high 640 cycles. frame_done pulse at trigger+641.
- Frame 2: second transmit_trigger with sig_param=16'h1234 → txd carries A5 02 12 34 48 in 800 cycles. Index returns to 1, so a third trigger sends frame 1.
- Dropped trigger: transmit_trigger 100 cycles into frame 1 → trig_dropped pulse. Frame 1 bytes unchanged. Next accepted trigger sends frame 2.
- Simultaneous and mid-frame meas_trigger:
  - meas_trigger and transmit_trigger in the same cycle after frame 1 → frame 1 resent.
  - meas_trigger mid-frame-1 → the next trigger sends frame 1.
- Reset mid-frame: rst_n low at cycle 300 of frame 2 → txd=1, busy=0 next edge. The next trigger sends frame 1 with a correct checksum.
- RESULT_TX_PARITY_EN, sig_type=7 → byte 07 is sent with parity bit 1. Frame 1 takes 704 cycles.
